// File: rtl/sheila_cycle_ctrl.sv
// sheila_cycle_ctrl
//   CPU bus-cycle controller and SHEILA (&FExx) chip-select decoder.
//   A free-running 4-bit phase counter (PH) paces a 1 MHz bus phase on the
//   16 MHz system clock. Each CPU cycle starts in DECODE, where the address
//   is decoded and latched into the active-low selects. Fast cycles last
//   8 CLKs. Accesses to 1 MHz devices are stretched so that the PHI_2-high
//   window lines up with the PHI_1M-high half of the 1 MHz bus.
//
// Ports
//   CLK        in   16 MHz system clock, rising edge
//   RESET      in   synchronous active-high reset
//   ADDR       in   CPU address, held for the whole CPU cycle
//   CPU_EN     out  one-CLK pulse on the last CLK of each CPU cycle
//   PHI_2      out  CPU phase-2
//   PHI_1M     out  1 MHz bus clock (PH 8..15)
//   ONE_MHZ_EN out  high when PH==15
//   STRETCHED  out  high for every CLK of a stretched cycle after DECODE
//   nCRTC .. nTUBE  out  registered active-low peripheral selects
module sheila_cycle_ctrl #(
  parameter logic [7:0] SHEILA_PAGE = 8'hFE,
  parameter logic       STRETCH_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  output logic        CPU_EN,
  output logic        PHI_2,
  output logic        PHI_1M,
  output logic        ONE_MHZ_EN,
  output logic        STRETCHED,
  output logic        nCRTC,
  output logic        nACIA,
  output logic        nSERPROC,
  output logic        nVIDULA,
  output logic        nROMSEL,
  output logic        nSYSVIA,
  output logic        nUSRVIA,
  output logic        nFDC,
  output logic        nADLC,
  output logic        nADC,
  output logic        nTUBE
);

  // Bit positions inside the internal select vector.
  localparam int BIT_CRTC    = 0;
  localparam int BIT_ACIA    = 1;
  localparam int BIT_SERPROC = 2;
  localparam int BIT_VIDULA  = 3;
  localparam int BIT_ROMSEL  = 4;
  localparam int BIT_SYSVIA  = 5;
  localparam int BIT_USRVIA  = 6;
  localparam int BIT_FDC     = 7;
  localparam int BIT_ADLC    = 8;
  localparam int BIT_ADC     = 9;
  localparam int BIT_TUBE    = 10;

  // Devices on the 1 MHz bus: CRTC, ACIA, SERPROC, SYSVIA, USRVIA, ADC.
  localparam logic [10:0] SLOW_MASK = 11'h267;

  typedef enum logic [1:0] {
    ST_DECODE      = 2'd0,
    ST_FAST        = 2'd1,
    ST_SLOW_ALIGN  = 2'd2,
    ST_SLOW_ACCESS = 2'd3
  } state_t;

  state_t      st_r;
  logic [3:0]  ph_r;
  logic [4:0]  cc_r;
  logic [10:0] sel_n_r;
  logic        cpu_en_r;
  logic        phi_2_r;
  logic        phi_1m_r;
  logic        one_mhz_en_r;
  logic        stretched_r;

  logic [3:0]  ph_inc_s;
  logic [10:0] addr_hit_s;
  logic        addr_slow_s;

  // Active-high one-hot device hit for an address; zero when unmapped.
  function automatic logic [10:0] sheila_decode(input logic [15:0] a);
    logic [10:0] hit;
    hit = 11'd0;
    if (a[15:8] == SHEILA_PAGE) begin
      case (a[7:5])
        3'd0: begin
          case (a[4:3])
            2'd0:    hit[BIT_CRTC]    = 1'b1;
            2'd1:    hit[BIT_ACIA]    = 1'b1;
            2'd2:    hit[BIT_SERPROC] = 1'b1;
            default: hit              = 11'd0;  // &FE18-&FE1F unmapped
          endcase
        end
        3'd1: begin
          if (a[4]) hit[BIT_ROMSEL] = 1'b1;
          else      hit[BIT_VIDULA] = 1'b1;
        end
        3'd2:    hit[BIT_SYSVIA] = 1'b1;
        3'd3:    hit[BIT_USRVIA] = 1'b1;
        3'd4:    hit[BIT_FDC]    = 1'b1;
        3'd5:    hit[BIT_ADLC]   = 1'b1;
        3'd6:    hit[BIT_ADC]    = 1'b1;
        default: hit[BIT_TUBE]   = 1'b1;
      endcase
    end else begin
      hit = 11'd0;
    end
    return hit;
  endfunction

  assign ph_inc_s = ph_r + 4'd1;

  // Address decode, only consumed while in DECODE.
  always_comb begin
    addr_hit_s  = sheila_decode(ADDR);
    addr_slow_s = |(addr_hit_s & SLOW_MASK);
  end

  // Cycle FSM. Every output flop is loaded with the value it must show in
  // the CLK that the state registers are moving into.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_r         <= ST_DECODE;
      ph_r         <= 4'd0;
      cc_r         <= 5'd0;
      sel_n_r      <= 11'h7FF;
      cpu_en_r     <= 1'b0;
      phi_2_r      <= 1'b0;
      phi_1m_r     <= 1'b0;
      one_mhz_en_r <= 1'b0;
      stretched_r  <= 1'b0;
    end else begin
      ph_r         <= ph_inc_s;
      phi_1m_r     <= ph_inc_s[3];
      one_mhz_en_r <= (ph_r == 4'd14);
      case (st_r)
        ST_DECODE: begin
          cc_r     <= 5'd1;
          sel_n_r  <= ~addr_hit_s;
          cpu_en_r <= 1'b0;
          phi_2_r  <= 1'b0;
          if (!addr_slow_s || !STRETCH_EN) begin
            st_r        <= ST_FAST;
            stretched_r <= 1'b0;
          end else if (ph_r == 4'd0) begin
            st_r        <= ST_SLOW_ACCESS;
            stretched_r <= 1'b1;
          end else begin
            st_r        <= ST_SLOW_ALIGN;
            stretched_r <= 1'b1;
          end
        end
        ST_FAST: begin
          if (cc_r == 5'd7) begin
            st_r        <= ST_DECODE;
            cc_r        <= 5'd0;
            sel_n_r     <= 11'h7FF;
            cpu_en_r    <= 1'b0;
            phi_2_r     <= 1'b0;
            stretched_r <= 1'b0;
          end else begin
            cc_r        <= cc_r + 5'd1;
            cpu_en_r    <= (cc_r == 5'd6);
            phi_2_r     <= (cc_r >= 5'd3);  // next CC in 4..7
            stretched_r <= 1'b0;
          end
        end
        ST_SLOW_ALIGN: begin
          // Idle out the current 1 MHz period; the access proper starts at PH 0.
          cc_r        <= cc_r + 5'd1;
          cpu_en_r    <= 1'b0;
          phi_2_r     <= 1'b0;
          stretched_r <= 1'b1;
          if (ph_r == 4'd15) st_r <= ST_SLOW_ACCESS;
          else               st_r <= ST_SLOW_ALIGN;
        end
        ST_SLOW_ACCESS: begin
          if (ph_r == 4'd15) begin
            st_r        <= ST_DECODE;
            cc_r        <= 5'd0;
            sel_n_r     <= 11'h7FF;
            cpu_en_r    <= 1'b0;
            phi_2_r     <= 1'b0;
            stretched_r <= 1'b0;
          end else begin
            cc_r        <= cc_r + 5'd1;
            cpu_en_r    <= (ph_r == 4'd14);
            phi_2_r     <= ph_inc_s[3];  // tracks PHI_1M during the access
            stretched_r <= 1'b1;
          end
        end
        default: begin
          st_r        <= ST_DECODE;
          cc_r        <= 5'd0;
          sel_n_r     <= 11'h7FF;
          cpu_en_r    <= 1'b0;
          phi_2_r     <= 1'b0;
          stretched_r <= 1'b0;
        end
      endcase
    end
  end

  assign CPU_EN     = cpu_en_r;
  assign PHI_2      = phi_2_r;
  assign PHI_1M     = phi_1m_r;
  assign ONE_MHZ_EN = one_mhz_en_r;
  assign STRETCHED  = stretched_r;
  assign nCRTC      = sel_n_r[BIT_CRTC];
  assign nACIA      = sel_n_r[BIT_ACIA];
  assign nSERPROC   = sel_n_r[BIT_SERPROC];
  assign nVIDULA    = sel_n_r[BIT_VIDULA];
  assign nROMSEL    = sel_n_r[BIT_ROMSEL];
  assign nSYSVIA    = sel_n_r[BIT_SYSVIA];
  assign nUSRVIA    = sel_n_r[BIT_USRVIA];
  assign nFDC       = sel_n_r[BIT_FDC];
  assign nADLC      = sel_n_r[BIT_ADLC];
  assign nADC       = sel_n_r[BIT_ADC];
  assign nTUBE      = sel_n_r[BIT_TUBE];

endmodule

// File: tb/tb_sheila_cycle_ctrl.sv
module tb_sheila_cycle_ctrl;

  // Select vector bit order used by this bench.
  localparam int S_NONE = -1;
  localparam int S_CRTC = 0, S_ACIA = 1, S_SERPROC = 2, S_VIDULA = 3;
  localparam int S_ROMSEL = 4, S_SYSVIA = 5, S_USRVIA = 6, S_FDC = 7;
  localparam int S_ADLC = 8, S_ADC = 9, S_TUBE = 10;

  logic        CLK;
  logic        RESET;
  logic [15:0] ADDR;
  logic [15:0] addr_b;

  logic cpu_en_a, phi_2_a, phi_1m_a, one_mhz_a, stretched_a;
  logic ncrtc_a, nacia_a, nserproc_a, nvidula_a, nromsel_a, nsysvia_a;
  logic nusrvia_a, nfdc_a, nadlc_a, nadc_a, ntube_a;

  logic cpu_en_b, phi_2_b, phi_1m_b, one_mhz_b, stretched_b;
  logic ncrtc_b, nacia_b, nserproc_b, nvidula_b, nromsel_b, nsysvia_b;
  logic nusrvia_b, nfdc_b, nadlc_b, nadc_b, ntube_b;

  logic [10:0] sel_a, sel_b;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;  // CLKs since the most recent reset release

  assign sel_a = {ntube_a, nadc_a, nadlc_a, nfdc_a, nusrvia_a, nsysvia_a,
                  nromsel_a, nvidula_a, nserproc_a, nacia_a, ncrtc_a};
  assign sel_b = {ntube_b, nadc_b, nadlc_b, nfdc_b, nusrvia_b, nsysvia_b,
                  nromsel_b, nvidula_b, nserproc_b, nacia_b, ncrtc_b};

  sheila_cycle_ctrl #(.SHEILA_PAGE(8'hFE), .STRETCH_EN(1'b1)) dut_a (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR),
    .CPU_EN(cpu_en_a), .PHI_2(phi_2_a), .PHI_1M(phi_1m_a),
    .ONE_MHZ_EN(one_mhz_a), .STRETCHED(stretched_a),
    .nCRTC(ncrtc_a), .nACIA(nacia_a), .nSERPROC(nserproc_a),
    .nVIDULA(nvidula_a), .nROMSEL(nromsel_a), .nSYSVIA(nsysvia_a),
    .nUSRVIA(nusrvia_a), .nFDC(nfdc_a), .nADLC(nadlc_a), .nADC(nadc_a),
    .nTUBE(ntube_a)
  );

  sheila_cycle_ctrl #(.SHEILA_PAGE(8'hFE), .STRETCH_EN(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .ADDR(addr_b),
    .CPU_EN(cpu_en_b), .PHI_2(phi_2_b), .PHI_1M(phi_1m_b),
    .ONE_MHZ_EN(one_mhz_b), .STRETCHED(stretched_b),
    .nCRTC(ncrtc_b), .nACIA(nacia_b), .nSERPROC(nserproc_b),
    .nVIDULA(nvidula_b), .nROMSEL(nromsel_b), .nSYSVIA(nsysvia_b),
    .nUSRVIA(nusrvia_b), .nFDC(nfdc_b), .nADLC(nadlc_b), .nADC(nadc_b),
    .nTUBE(ntube_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step one CLK and sample just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    t++;
  endtask

  function automatic logic [10:0] sel_exp(input int b);
    logic [10:0] v;
    v = 11'h7FF;
    if (b >= 0) v[b] = 1'b0;
    return v;
  endfunction

  // Run one dut_a cycle from its DECODE CLK and check every CLK of it.
  task automatic check_cycle(input string tag, input logic [15:0] addr,
                             input int sel_bit, input int len, input logic slow);
    int ph0;
    int ph;
    logic exp_phi2;
    ph0  = t % 16;
    ADDR = addr;
    chk_eq($sformatf("%s_c0_sel", tag), {21'd0, sel_a}, {21'd0, 11'h7FF});
    chk_eq($sformatf("%s_c0_cpuen", tag), {31'd0, cpu_en_a}, 32'd0);
    for (int c = 1; c < len; c++) begin
      tick();
      if (c == 2) ADDR = addr ^ 16'h0080;  // late address change must be ignored
      ph = (ph0 + c) % 16;
      exp_phi2 = slow ? (c >= len - 8) : (c >= 4);
      chk_eq($sformatf("%s_c%0d_sel", tag, c), {21'd0, sel_a}, {21'd0, sel_exp(sel_bit)});
      chk_eq($sformatf("%s_c%0d_cpuen", tag, c), {31'd0, cpu_en_a}, {31'd0, (c == len - 1)});
      chk_eq($sformatf("%s_c%0d_str", tag, c), {31'd0, stretched_a}, {31'd0, slow});
      chk_eq($sformatf("%s_c%0d_phi2", tag, c), {31'd0, phi_2_a}, {31'd0, exp_phi2});
      chk_eq($sformatf("%s_c%0d_phi1m", tag, c), {31'd0, phi_1m_a}, {31'd0, (ph >= 8)});
      chk_eq($sformatf("%s_c%0d_1mhz", tag, c), {31'd0, one_mhz_a}, {31'd0, (ph == 15)});
    end
    tick();
  endtask

  initial begin
    RESET  = 1'b1;
    ADDR   = 16'h8000;
    addr_b = 16'h8000;
    tick(); tick(); tick();

    // Reset state.
    chk_eq("rst_sel", {21'd0, sel_a}, {21'd0, 11'h7FF});
    chk_eq("rst_cpuen", {31'd0, cpu_en_a}, 32'd0);
    chk_eq("rst_phi2", {31'd0, phi_2_a}, 32'd0);
    chk_eq("rst_phi1m", {31'd0, phi_1m_a}, 32'd0);
    chk_eq("rst_1mhz", {31'd0, one_mhz_a}, 32'd0);
    chk_eq("rst_str", {31'd0, stretched_a}, 32'd0);

    // Release and run three fast non-SHEILA cycles.
    RESET = 1'b0;
    t = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) tick();
      chk_eq($sformatf("boot_k%0d_sel", k), {21'd0, sel_a}, {21'd0, 11'h7FF});
      chk_eq($sformatf("boot_k%0d_cpuen", k), {31'd0, cpu_en_a}, {31'd0, (k % 8 == 7)});
      chk_eq($sformatf("boot_k%0d_phi2", k), {31'd0, phi_2_a}, {31'd0, (k % 8 >= 4)});
      chk_eq($sformatf("boot_k%0d_phi1m", k), {31'd0, phi_1m_a}, {31'd0, (k % 16 >= 8)});
      chk_eq($sformatf("boot_k%0d_1mhz", k), {31'd0, one_mhz_a}, {31'd0, (k % 16 == 15)});
    end
    tick();

    // STRETCH_EN=0 instance: ADC access at PH=8 stays fast.
    addr_b = 16'hFEC0;
    chk_eq("nostr_c0_sel", {21'd0, sel_b}, {21'd0, 11'h7FF});
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c == 2) addr_b = 16'h8000;
      chk_eq($sformatf("nostr_c%0d_sel", c), {21'd0, sel_b}, {21'd0, sel_exp(S_ADC)});
      chk_eq($sformatf("nostr_c%0d_cpuen", c), {31'd0, cpu_en_b}, {31'd0, (c == 7)});
      chk_eq($sformatf("nostr_c%0d_str", c), {31'd0, stretched_b}, 32'd0);
    end
    tick();

    // dut_a is back in DECODE at PH=0 (t=32).
    check_cycle("fdc",     16'hFE80, S_FDC,     8,  1'b0);  // PH 0
    check_cycle("vidula",  16'hFE20, S_VIDULA,  8,  1'b0);  // PH 8
    check_cycle("acia",    16'hFE08, S_ACIA,    16, 1'b1);  // PH 0, aligned
    check_cycle("romsel",  16'hFE3F, S_ROMSEL,  8,  1'b0);  // PH 0
    check_cycle("sysvia",  16'hFE40, S_SYSVIA,  24, 1'b1);  // PH 8, misaligned
    check_cycle("crtc",    16'hFE00, S_CRTC,    16, 1'b1);  // PH 0
    check_cycle("adlc",    16'hFEBF, S_ADLC,    8,  1'b0);  // PH 0
    check_cycle("serproc", 16'hFE17, S_SERPROC, 24, 1'b1);  // PH 8
    check_cycle("tube",    16'hFEFF, S_TUBE,    8,  1'b0);  // PH 0
    check_cycle("unmap",   16'hFE18, S_NONE,    8,  1'b0);  // PH 8
    check_cycle("otherpg", 16'hFD08, S_NONE,    8,  1'b0);  // PH 0
    check_cycle("usrvia",  16'hFE7F, S_USRVIA,  24, 1'b1);  // PH 8
    check_cycle("adc",     16'hFEDF, S_ADC,     16, 1'b1);  // PH 0
    check_cycle("fdc_top", 16'hFE9F, S_FDC,     8,  1'b0);  // PH 0
    check_cycle("vid_top", 16'hFE2F, S_VIDULA,  8,  1'b0);  // PH 8

    // Reset in the middle of a slow USRVIA access starting at PH=0.
    ADDR = 16'hFE60;
    for (int c = 1; c <= 10; c++) tick();
    chk_eq("mid_c10_sel", {21'd0, sel_a}, {21'd0, sel_exp(S_USRVIA)});
    chk_eq("mid_c10_str", {31'd0, stretched_a}, 32'd1);
    RESET = 1'b1;
    tick();
    chk_eq("mid_rst_sel", {21'd0, sel_a}, {21'd0, 11'h7FF});
    chk_eq("mid_rst_cpuen", {31'd0, cpu_en_a}, 32'd0);
    chk_eq("mid_rst_str", {31'd0, stretched_a}, 32'd0);
    chk_eq("mid_rst_phi2", {31'd0, phi_2_a}, 32'd0);
    chk_eq("mid_rst_phi1m", {31'd0, phi_1m_a}, 32'd0);
    RESET = 1'b0;
    ADDR  = 16'h8000;
    t = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      chk_eq($sformatf("post_k%0d_sel", k), {21'd0, sel_a}, {21'd0, 11'h7FF});
      chk_eq($sformatf("post_k%0d_cpuen", k), {31'd0, cpu_en_a}, {31'd0, (k == 7)});
      chk_eq($sformatf("post_k%0d_phi1m", k), {31'd0, phi_1m_a}, {31'd0, (k >= 8)});
      chk_eq($sformatf("post_k%0d_str", k), {31'd0, stretched_a}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sheila_cycle_ctrl.md
# sheila_cycle_ctrl

CPU bus-cycle controller and SHEILA (&FExx) chip-select decoder. It generates the CPU cycle enable and PHI_2, and decodes the CPU address into active-low peripheral selects, including nFDC, nADC, nTUBE, nADLC and nACIA, which the peripheral blocks consume. Accesses to 1 MHz peripherals are stretched so that their PHI_2-high window aligns with the 1 MHz bus phase.

## Interface
Parameters:
- SHEILA_PAGE, 8'hFE, value of ADDR[15:8] that enables decoding.
- STRETCH_EN, 1, 0 makes every cycle fast (no 1 MHz stretch); intended for bring-up.

Ports:
- CLK  in  1  16 MHz system clock; all state is updated on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  16  CPU address. A new value is valid from the CLK after CPU_EN and is held for the whole cycle.
- CPU_EN  out  1  one-CLK pulse on the last CLK of each CPU cycle; the CPU advances on it.
- PHI_2  out  1  CPU phase-2, high for the second half of each cycle.
- PHI_1M  out  1  1 MHz bus clock, high when PH is 8..15.
- ONE_MHZ_EN  out  1  high when PH==15.
- STRETCHED  out  1  high for every CLK of a stretched cycle.
- nCRTC, nACIA, nSERPROC, nVIDULA, nROMSEL, nSYSVIA, nUSRVIA, nFDC, nADLC, nADC, nTUBE  out  1 each  registered active-low selects.

## Operation
- PH: free-running 4-bit phase counter (0..15) with wrap-around.
- CC: cycle counter, reset to 0 on the CLK after CPU_EN.
- The first CPU cycle after reset starts with PH=0. Cycle starts therefore always fall on PH 0 or 8.
- Decode applies only when ADDR[15:8]==SHEILA_PAGE. It uses ADDR[7:0]:
  - 00-07 CRTC, 08-0F ACIA, 10-17 SERPROC, 18-1F none
  - 20-2F VIDULA, 30-3F ROMSEL, 40-5F SYSVIA, 60-7F USRVIA
  - 80-9F FDC, A0-BF ADLC, C0-DF ADC, E0-FF TUBE
- Slow (1 MHz) devices: CRTC, ACIA, SERPROC, SYSVIA, USRVIA, ADC. All other addresses, including unmapped ones, are fast.
- State machine:
  - DECODE (CC=0): sample the decode. Next state is FAST if the access is fast or STRETCH_EN=0. If the access is slow, next state is SLOW_ACCESS when PH==0, otherwise SLOW_ALIGN.
  - FAST: total cycle length L=8.
  - SLOW_ALIGN: wait until PH==15, then go to SLOW_ACCESS with no CPU_EN. Total L=24.
  - SLOW_ACCESS: runs until PH==15. Total L=16 when entered directly from DECODE at PH=0.
  - In every case, CPU_EN is asserted on CC=L-1 and the next state is DECODE.
- Selects:
  - Registered at the end of DECODE, so a select is low from CC=1 through CC=L-1 inclusive.
  - All selects are high in DECODE.
  - At most one select is low at any time.
- PHI_2:
  - High for CC 4..7 in fast cycles.
  - High for the final 8 CLKs of slow cycles, which coincide exactly with PHI_1M high (PH 8..15).
- STRETCHED: high from CC=1 to CC=L-1 of a slow cycle.
- ADDR changes outside DECODE are ignored; the decode is already latched.

## Timing
- Reset values: PH=0, CC=0, state DECODE, all selects high, CPU_EN=0, PHI_2=0, PHI_1M=0, ONE_MHZ_EN=0, STRETCHED=0.
- Reset mid-cycle: on the next CLK every output returns to its reset value, with no CPU_EN for the aborted cycle. The first cycle after release starts at PH=0.
- Decode latency: a select goes low one CLK after DECODE and goes high on the CLK after CPU_EN, i.e. the next DECODE.
- Back-to-back cycles: there are no idle CLKs between CPU_EN and the next DECODE.
- CPU_EN rate: one every 8 CLKs for fast cycles. Slow cycles adds 8 or 16 CLKs.
- Slow cycles always end with PH==15, so CPU_EN and ONE_MHZ_EN coincide on that CLK.

## Test plan
- Reset: hold RESET for 3 CLKs, then release with ADDR=&8000. All selects stay high; CPU_EN is high at CLKs 7, 15, 23 after release; PHI_2 is high at CLKs 4-7.
- Fast SHEILA access: ADDR=&FE80 in a cycle starting at PH=0. nFDC is low at CC1..7, CPU_EN at CC7, STRETCHED=0, all other selects high.
- Slow access, aligned: ADDR=&FE08 at PH=0. nACIA is low at CC1..15, PHI_2 high at CC8..15, CPU_EN and ONE_MHZ_EN both at CC15, STRETCHED high at CC1..15.
- Slow access, misaligned: ADDR=&FE40 at PH=8. Cycle length is 24; nSYSVIA is low at CC1..23; PHI_2 is high exactly while PHI_1M is high (CC16..23); CPU_EN at CC23.
- STRETCH_EN=0: ADDR=&FEC0 at PH=8. nADC is low at CC1..7, CPU_EN at CC7, STRETCHED=0.
- Reset mid slow cycle: assert RESET at CC10 of an &FE60 access. nUSRVIA goes high on the next CLK; no CPU_EN is seen; after release the first CPU_EN occurs 8 CLKs later, with PH=0 at the start of that cycle.
